// File: rtl/coincidence_pkg.sv
// Shared constants and state encodings for the coincidence counter's
// PC-to-FPGA command link.
package coincidence_pkg;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  localparam logic [7:0] CMD_SET_PERIOD   = 8'h01;
  localparam logic [7:0] CMD_CHAN_EN      = 8'h02;
  localparam logic [7:0] CMD_TEST_PATTERN = 8'h03;

  typedef enum logic [2:0] {
    ByteIdle,
    ByteStart,
    ByteData,
    ByteStop,
    ByteWaitHigh
  } byte_state_e;

  typedef enum logic [1:0] {
    PktHunt,
    PktCmd,
    PktData,
    PktChk
  } pkt_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling FSM,
// one-cycle byte_valid and frame_err strobes.
module uart_byte_rx
  import coincidence_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 2604
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  logic            rxd_meta_q, rxd_sync_q;
  byte_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ByteIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_o <= 1'b0;
      byte_data_o  <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      unique case (state_q)
        ByteIdle: begin
          if (!rxd_sync_q) begin
            state_q   <= ByteStart;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        ByteStart: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            state_q <= rxd_sync_q ? ByteIdle : ByteData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ByteData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rxd_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= ByteStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ByteStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rxd_sync_q) begin
              byte_valid_o <= 1'b1;
              byte_data_o  <= shift_q;
              state_q      <= ByteIdle;
            end else begin
              frame_err_o <= 1'b1;
              state_q     <= ByteWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ByteWaitHigh: begin
          if (rxd_sync_q) begin
            state_q <= ByteIdle;
          end
        end
        default: state_q <= ByteIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Command-packet decoder: frames SYNC,CMD,D0..D3,CHK packets from the byte
// receiver, checks the XOR checksum and strobes validated commands.
module uart_cmd_rx
  import coincidence_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        UART_RXD,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_data,
  output logic        frame_err,
  output logic        chk_err,
  output logic        busy
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCycles - 1);

  logic       byte_valid;
  logic [7:0] byte_data;

  pkt_state_e     pkt_state_q;
  logic [1:0]     byte_idx_q;
  logic [7:0]     acc_q;
  logic [7:0]     code_sh_q;
  logic [31:0]    data_sh_q;
  logic [ToW-1:0] to_cnt_q;
  logic           to_hit;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clock_50    (clock_50),
    .reset       (reset),
    .rxd_i       (UART_RXD),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .frame_err_o (frame_err)
  );

  assign busy   = (pkt_state_q != PktHunt);
  assign to_hit = (to_cnt_q == ToLast) && !byte_valid;

  // Cycles since the last accepted byte; saturates at the limit.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (pkt_state_q == PktHunt || byte_valid) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != ToLast) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      pkt_state_q <= PktHunt;
      byte_idx_q  <= '0;
      acc_q       <= '0;
      code_sh_q   <= '0;
      data_sh_q   <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_data    <= '0;
      chk_err     <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      chk_err   <= 1'b0;
      if (pkt_state_q == PktHunt) begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          pkt_state_q <= PktCmd;
        end
      end else if (frame_err || to_hit) begin
        pkt_state_q <= PktHunt;
      end else if (byte_valid) begin
        unique case (pkt_state_q)
          PktCmd: begin
            code_sh_q   <= byte_data;
            acc_q       <= byte_data;
            byte_idx_q  <= '0;
            pkt_state_q <= PktData;
          end
          PktData: begin
            data_sh_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
            acc_q <= acc_q ^ byte_data;
            if (byte_idx_q == 2'd3) begin
              pkt_state_q <= PktChk;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
          PktChk: begin
            if (byte_data == acc_q) begin
              cmd_valid <= 1'b1;
              cmd_code  <= code_sh_q;
              cmd_data  <= data_sh_q;
            end else begin
              chk_err <= 1'b1;
            end
            pkt_state_q <= PktHunt;
          end
          default: pkt_state_q <= PktHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit.
module tb_uart_cmd_rx;

  localparam int unsigned Cpb = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        frame_err;
  logic        chk_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_frame = 0;
  int n_chk = 0;
  int n_viol = 0;
  logic prev_valid = 1'b0, prev_frame = 1'b0, prev_chk = 1'b0;

  uart_cmd_rx #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_BITS(20)
  ) dut (
    .clock_50 (clk),
    .reset    (rst),
    .UART_RXD (rxd),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_data (cmd_data),
    .frame_err(frame_err),
    .chk_err  (chk_err),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  // Strobe counters plus width / exclusivity watch.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) n_valid++;
      if (frame_err) n_frame++;
      if (chk_err) n_chk++;
      if ((cmd_valid && prev_valid) || (frame_err && prev_frame) || (chk_err && prev_chk))
        n_viol++;
      if (int'(cmd_valid) + int'(frame_err) + int'(chk_err) > 1) n_viol++;
      prev_valid = cmd_valid;
      prev_frame = frame_err;
      prev_chk   = chk_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (Cpb) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Bytes are sent MSB-first from the vector: p[55:48] goes out first.
  task automatic send_pkt(input logic [55:0] p);
    for (int i = 6; i >= 0; i--) begin
      send_byte(p[i*8 +: 8], 1'b1);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_code", {24'd0, cmd_code}, 32'd0);
    check("rst_cmd_data", cmd_data, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_chk_err", {31'd0, chk_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good packet; busy checked mid-packet.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h09, 1'b1);
    repeat (4) @(negedge clk);
    check("t1_n_valid", n_valid, 1);
    check("t1_code", {24'd0, cmd_code}, 32'h01);
    check("t1_data", cmd_data, 32'h12345678);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // Bad checksum.
    send_pkt(56'hA5_01_78_56_34_12_08);
    check("t2_n_chk", n_chk, 1);
    check("t2_n_valid", n_valid, 1);
    check("t2_code_kept", {24'd0, cmd_code}, 32'h01);
    check("t2_data_kept", cmd_data, 32'h12345678);

    // Junk before sync, and 0xA5 as payload.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_pkt(56'hA5_02_A5_00_00_00_A7);
    check("t3_n_valid", n_valid, 2);
    check("t3_code", {24'd0, cmd_code}, 32'h02);
    check("t3_data", cmd_data, 32'h000000A5);

    // Short low glitch on an idle line.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_glitch_valid", n_valid, 2);
    check("t4_glitch_frame", n_frame, 0);
    check("t4_glitch_chk", n_chk, 1);
    check("t4_glitch_busy", {31'd0, busy}, 32'd0);
    send_pkt(56'hA5_03_05_00_00_00_06);
    check("t4_n_valid", n_valid, 3);
    check("t4_code", {24'd0, cmd_code}, 32'h03);
    check("t4_data", cmd_data, 32'h00000005);

    // Framing error on D1 aborts the packet.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b0);
    repeat (4) @(negedge clk);
    check("t5_n_frame", n_frame, 1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_n_valid", n_valid, 3);
    send_pkt(56'hA5_02_0F_00_00_00_0D);
    check("t5_next_valid", n_valid, 4);
    check("t5_next_code", {24'd0, cmd_code}, 32'h02);
    check("t5_next_data", cmd_data, 32'h0000000F);

    // Inter-byte timeout.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    repeat (21 * Cpb) @(negedge clk);
    check("t6_busy_timeout", {31'd0, busy}, 32'd0);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h09, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_n_valid", n_valid, 4);
    check("t6_n_chk", n_chk, 1);
    check("t6_busy_end", {31'd0, busy}, 32'd0);

    // Reset mid-byte clears everything at once.
    send_byte(8'hA5, 1'b1);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7_code", {24'd0, cmd_code}, 32'h00);
    check("t7_data", cmd_data, 32'h0);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_valid", {31'd0, cmd_valid}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_pkt(56'hA5_01_10_00_00_00_11);
    check("t7_post_valid", n_valid, 5);
    check("t7_post_code", {24'd0, cmd_code}, 32'h01);
    check("t7_post_data", cmd_data, 32'h00000010);

    check("strobe_shape", n_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
